// File: rtl/muldiv_unit_if.sv
// Issue/writeback bundle between the control unit, the multiply/divide unit
// and the register file write port.
//
// Handshake: an operation is accepted on a rising edge where start=1 and
// ready=1; op/rd/opa/opb are sampled on that edge only. start while ready=0
// is dropped, not queued. wb_en is a one-cycle strobe with no backpressure;
// wb_addr/wb_data are meaningful only while wb_en=1.
interface muldiv_unit_if #(
    parameter int XLEN  = 16,
    parameter int RADDR = 4
);
    logic             start;
    logic [1:0]       op;
    logic [RADDR-1:0] rd;
    logic [XLEN-1:0]  opa;
    logic [XLEN-1:0]  opb;
    logic             kill;
    logic             ready;
    logic             busy;
    logic [RADDR-1:0] busy_rd;
    logic             wb_en;
    logic [RADDR-1:0] wb_addr;
    logic [XLEN-1:0]  wb_data;
    logic [1:0]       state_dbg;

    modport master (
        output start, op, rd, opa, opb, kill,
        input  ready, busy, busy_rd, wb_en, wb_addr, wb_data, state_dbg
    );

    modport slave (
        input  start, op, rd, opa, opb, kill,
        output ready, busy, busy_rd, wb_en, wb_addr, wb_data, state_dbg
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: shift-add multiply and restoring
// divide, one iteration per cycle for XLEN cycles, then a single-cycle
// register-file writeback. Op encoding: 00 MUL, 01 MULH, 10 DIVU, 11 REMU.
module muldiv_unit #(
    parameter int XLEN  = 16,
    parameter int RADDR = 4
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       op_q;
    logic [RADDR-1:0] rd_q;
    logic [XLEN-1:0]  dsr_q;      // multiplicand for MUL*, divisor for DIV*
    logic [XLEN-1:0]  hi_q;       // product high half / partial remainder
    logic [XLEN-1:0]  lo_q;       // multiplier shifting out / quotient shifting in
    logic [CW-1:0]    cnt_q;
    logic [RADDR-1:0] wb_addr_q;
    logic [XLEN-1:0]  wb_data_q;

    logic             accept;
    logic             last_iter;
    logic [XLEN:0]    mul_sum;
    logic [XLEN-1:0]  mul_hi;
    logic [XLEN-1:0]  mul_lo;
    logic [XLEN:0]    div_shift;
    logic [XLEN-1:0]  div_diff;
    logic             div_ok;
    logic [XLEN-1:0]  div_hi;
    logic [XLEN-1:0]  div_lo;
    logic [XLEN-1:0]  hi_nxt;
    logic [XLEN-1:0]  lo_nxt;
    logic [XLEN-1:0]  result;

    assign accept    = bus.start && (state == S_IDLE);
    assign last_iter = (state == S_CALC) && (cnt_q == CW'(XLEN - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; kill wins over completion.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start) state_nxt = S_CALC;
            S_CALC: begin
                if (bus.kill)       state_nxt = S_IDLE;
                else if (last_iter) state_nxt = S_WB;
            end
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One multiply or divide iteration from the current registers.
    always_comb begin
        // Shift-add: add multiplicand into the high half if the multiplier
        // LSB is set, then shift the whole {carry, hi, lo} right by one.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dsr_q} : '0);
        mul_hi    = mul_sum[XLEN:1];
        mul_lo    = {mul_sum[0], lo_q[XLEN-1:1]};
        // Restoring divide: bring in the next dividend bit, subtract the
        // divisor when it fits. The remainder always fits in XLEN bits, so
        // the modular difference is exact whenever div_ok is set. A zero
        // divisor always "fits", giving all-ones quotient and rem = dividend.
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ok    = (div_shift >= {1'b0, dsr_q});
        div_diff  = div_shift[XLEN-1:0] - dsr_q;
        div_hi    = div_ok ? div_diff : div_shift[XLEN-1:0];
        div_lo    = {lo_q[XLEN-2:0], div_ok};
        hi_nxt    = op_q[1] ? div_hi : mul_hi;
        lo_nxt    = op_q[1] ? div_lo : mul_lo;
        result    = '0;
        case (op_q)
            2'b00:   result = lo_nxt;
            2'b01:   result = hi_nxt;
            2'b10:   result = lo_nxt;
            default: result = hi_nxt;
        endcase
    end

    // Operand capture at accept, iteration in CALC, result capture on the
    // final iteration so wb_data/wb_addr hold between writebacks.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            rd_q      <= '0;
            dsr_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else if (accept) begin
            op_q  <= bus.op;
            rd_q  <= bus.rd;
            dsr_q <= bus.op[1] ? bus.opb : bus.opa;
            lo_q  <= bus.op[1] ? bus.opa : bus.opb;
            hi_q  <= '0;
            cnt_q <= '0;
        end else if (state == S_CALC) begin
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            cnt_q <= last_iter ? '0 : cnt_q + 1'b1;
            if (last_iter && !bus.kill) begin
                wb_data_q <= result;
                wb_addr_q <= rd_q;
            end
        end
    end

    // Status decode from state. The write strobe is additionally dropped by
    // kill or reset in the WB cycle itself so an aborted op never writes.
    always_comb begin
        bus.ready     = (state == S_IDLE);
        bus.busy      = (state != S_IDLE);
        bus.busy_rd   = (state != S_IDLE) ? rd_q : '0;
        bus.wb_en     = (state == S_WB) && !bus.kill && !reset;
        bus.wb_addr   = wb_addr_q;
        bus.wb_data   = wb_data_q;
        bus.state_dbg = state;
    end
endmodule
